// File: rtl/race_hud_ctrl.sv
// race_hud_ctrl: race sequencing FSM (idle, 3-2-1-GO, racing, blinking finish)
// plus fixed-priority font-ROM arbiter with a 2-clk pixel-aligned text_on.
module race_hud_ctrl #(
    parameter int COUNT_FRAMES       = 60,
    parameter int BLINK_FRAMES       = 30,
    parameter int FINISH_HOLD_FRAMES = 300
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        frame_tick_i,
    input  logic        start_i,
    input  logic        lap_done_i,
    input  logic        count_req_on_i,
    input  logic [10:0] count_req_addr_i,
    input  logic [2:0]  count_req_bit_i,
    input  logic        finish_req_on_i,
    input  logic [10:0] finish_req_addr_i,
    input  logic [2:0]  finish_req_bit_i,
    input  logic [7:0]  rom_data_i,
    output logic [10:0] rom_addr_o,
    output logic        text_on_o,
    output logic        count_en_o,
    output logic [1:0]  count_digit_o,
    output logic        finish_en_o,
    output logic        race_active_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, RACE = 2'd2, FINISH = 2'd3} state_t;
    localparam int FMAX = FINISH_HOLD_FRAMES > COUNT_FRAMES + 1 ? FINISH_HOLD_FRAMES : COUNT_FRAMES + 1;
    localparam int FW   = $clog2(FMAX) < 9 ? 9 : $clog2(FMAX);
    localparam int BW   = $clog2(BLINK_FRAMES + 1);

    state_t          state_q, state_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            blink_q, blink_d;
    logic            count_en_q, count_en_d, finish_en_q, finish_en_d, race_active_q, race_active_d;
    logic [10:0]     rom_addr_q, sel_addr;
    logic [2:0]      bit1_q, bit2_q, sel_bit;
    logic            on1_q, on2_q, sel_on;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            digit_q       <= 2'd3;
            bcnt_q        <= '0;
            blink_q       <= 1'b0;
            count_en_q    <= 1'b0;
            finish_en_q   <= 1'b0;
            race_active_q <= 1'b0;
            rom_addr_q    <= '0;
            on1_q         <= 1'b0;
            on2_q         <= 1'b0;
            bit1_q        <= '0;
            bit2_q        <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            digit_q       <= digit_d;
            bcnt_q        <= bcnt_d;
            blink_q       <= blink_d;
            count_en_q    <= count_en_d;
            finish_en_q   <= finish_en_d;
            race_active_q <= race_active_d;
            rom_addr_q    <= sel_addr;
            on1_q         <= sel_on;
            on2_q         <= on1_q;
            bit1_q        <= sel_bit;
            bit2_q        <= bit1_q;
        end
    end

    // In RACE fcnt saturates at COUNT_FRAMES so a long race never re-shows GO.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        digit_d = digit_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        case (state_q)
            IDLE: begin
                digit_d = 2'd3;
                fcnt_d  = '0;
                if (start_i) state_d = COUNT;
            end
            COUNT: begin
                if (frame_tick_i) begin
                    if (fcnt_q == FW'(COUNT_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        digit_d = digit_q - 2'd1;
                        if (digit_q == 2'd1) state_d = RACE;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            RACE: begin
                if (lap_done_i) begin
                    state_d = FINISH;
                    fcnt_d  = '0;
                    bcnt_d  = '0;
                    blink_d = 1'b1;
                end else if (frame_tick_i && fcnt_q < FW'(COUNT_FRAMES)) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            FINISH: begin
                if (frame_tick_i) begin
                    if (fcnt_q == FW'(FINISH_HOLD_FRAMES - 1)) begin
                        state_d = IDLE;
                        fcnt_d  = '0;
                        digit_d = 2'd3;
                    end else begin
                        fcnt_d  = fcnt_q + 1'b1;
                        bcnt_d  = (bcnt_q == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt_q + 1'b1;
                        blink_d = (bcnt_q == BW'(BLINK_FRAMES - 1)) ? ~blink_q : blink_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_en_d    = (state_d == COUNT) || (state_d == RACE && fcnt_d < FW'(COUNT_FRAMES));
        finish_en_d   = (state_d == FINISH) && blink_d;
        race_active_d = state_d == RACE;
    end

    always_comb begin
        sel_addr = finish_req_on_i ? finish_req_addr_i : count_req_on_i ? count_req_addr_i : '0;
        sel_bit  = finish_req_on_i ? finish_req_bit_i : count_req_on_i ? count_req_bit_i : '0;
        sel_on   = finish_req_on_i ? finish_en_q : (count_req_on_i & count_en_q);
    end

    assign text_on_o     = on2_q & rom_data_i[3'd7 - bit2_q];
    assign rom_addr_o    = rom_addr_q;
    assign count_en_o    = count_en_q;
    assign count_digit_o = digit_q;
    assign finish_en_o   = finish_en_q;
    assign race_active_o = race_active_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_race_hud_ctrl.sv
// tb_race_hud_ctrl: arbitration table, directed race/banner/pixel/reset
// sequences, then randomized traffic against a tick-count reference model.
module tb_race_hud_ctrl;
    localparam int CF = 2, BF = 2, FH = 8;

    logic        clk = 1'b0, reset_n = 1'b0, frame_tick = 1'b0, start = 1'b0, lap_done = 1'b0;
    logic        count_req_on = 1'b0, finish_req_on = 1'b0;
    logic [10:0] count_req_addr = '0, finish_req_addr = '0;
    logic [2:0]  count_req_bit = '0, finish_req_bit = '0;
    logic [7:0]  rom_data = 8'hFF;
    logic [10:0] rom_addr;
    logic        text_on, count_en, finish_en, race_active;
    logic [1:0]  count_digit, state;

    int tests = 0, fails = 0;

    race_hud_ctrl #(.COUNT_FRAMES(CF), .BLINK_FRAMES(BF), .FINISH_HOLD_FRAMES(FH)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .frame_tick_i(frame_tick), .start_i(start),
        .lap_done_i(lap_done), .count_req_on_i(count_req_on), .count_req_addr_i(count_req_addr),
        .count_req_bit_i(count_req_bit), .finish_req_on_i(finish_req_on),
        .finish_req_addr_i(finish_req_addr), .finish_req_bit_i(finish_req_bit),
        .rom_data_i(rom_data), .rom_addr_o(rom_addr), .text_on_o(text_on), .count_en_o(count_en),
        .count_digit_o(count_digit), .finish_en_o(finish_en), .race_active_o(race_active),
        .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f_on;
        logic [10:0] f_addr;
        logic        c_on;
        logic [10:0] c_addr;
        logic [10:0] exp_addr;
    } arb_vec_t;

    // model: mode 0 idle, 1 started (k = ticks since start), 3 finish (j = ticks since lap_done)
    int          m_mode, m_k, m_j;
    logic [10:0] m_addr;
    logic        m_on1, m_on2;
    logic [2:0]  m_b1, m_b2;
    int          e_state, e_digit;
    logic        e_cnt, e_fin, e_race;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (9) cyc();
    endtask

    task automatic model_exp();
        e_state = m_mode == 0 ? 0 : m_mode == 3 ? 3 : (m_k < 3 * CF ? 1 : 2);
        e_digit = m_mode == 0 ? 3 : m_mode == 3 ? 0 : (m_k < 3 * CF ? 3 - m_k / CF : 0);
        e_cnt   = m_mode == 1 && m_k < 4 * CF;
        e_fin   = m_mode == 3 && ((m_j / BF) % 2 == 0);
        e_race  = m_mode == 1 && m_k >= 3 * CF;
    endtask

    initial begin
        arb_vec_t arb[6];
        int dig_exp[8] = '{3, 2, 2, 1, 1, 0, 0, 0};
        arb[0] = '{1'b1, 11'h234, 1'b1, 11'h1A5, 11'h234};
        arb[1] = '{1'b0, 11'h234, 1'b1, 11'h1A5, 11'h1A5};
        arb[2] = '{1'b0, 11'h234, 1'b0, 11'h1A5, 11'h000};
        arb[3] = '{1'b1, 11'h7FF, 1'b0, 11'h001, 11'h7FF};
        arb[4] = '{1'b0, 11'h000, 1'b1, 11'h003, 11'h003};
        arb[5] = '{1'b1, 11'h000, 1'b1, 11'h555, 11'h000};

        cyc();
        cyc();
        reset_n = 1'b1;
        chk("reset_state", state, 0);
        chk("reset_digit", count_digit, 3);
        chk("reset_count_en", count_en, 0);
        chk("reset_finish_en", finish_en, 0);
        chk("reset_race_active", race_active, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_text_on", text_on, 0);

        foreach (arb[i]) begin
            finish_req_on = arb[i].f_on; finish_req_addr = arb[i].f_addr;
            count_req_on = arb[i].c_on; count_req_addr = arb[i].c_addr;
            cyc();
            chk($sformatf("arb_vec%0d_rom_addr", i), rom_addr, arb[i].exp_addr);
        end
        finish_req_on = 1'b0; count_req_on = 1'b0;

        lap_done = 1'b1; cyc(); lap_done = 1'b0;
        chk("lap_in_idle_state", state, 0);

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_state", state, 1);
        chk("start_digit", count_digit, 3);
        chk("start_count_en", count_en, 1);
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk($sformatf("cd_tick%0d_digit", t), count_digit, dig_exp[t-1]);
            chk($sformatf("cd_tick%0d_race", t), race_active, t >= 6);
            chk($sformatf("cd_tick%0d_count_en", t), count_en, t < 8);
        end

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_in_race_state", state, 2);
        chk("start_in_race_digit", count_digit, 0);

        // lap_done with a coincident tick: the tick must not advance the banner
        lap_done = 1'b1; frame_tick = 1'b1; cyc(); lap_done = 1'b0; frame_tick = 1'b0;
        chk("sim_lap_state", state, 3);
        chk("sim_lap_finish_en", finish_en, 1);
        chk("sim_lap_race", race_active, 0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk($sformatf("fin_tick%0d_state", t), state, t < 8 ? 3 : 0);
            chk($sformatf("fin_tick%0d_finish_en", t), finish_en, t < 8 && ((t / BF) % 2 == 0));
            chk($sformatf("fin_tick%0d_race", t), race_active, 0);
        end

        start = 1'b1; cyc(); start = 1'b0;
        repeat (6) tick();
        lap_done = 1'b1; cyc(); lap_done = 1'b0;
        chk("fin2_finish_en", finish_en, 1);
        finish_req_on = 1'b1; finish_req_addr = 11'h234;
        count_req_on = 1'b1; count_req_addr = 11'h1A5; count_req_bit = 3'd0;
        cyc();
        chk("arb_both_rom_addr", rom_addr, 11'h234);
        finish_req_on = 1'b0;
        cyc();
        chk("arb_count_rom_addr", rom_addr, 11'h1A5);
        count_req_on = 1'b0;
        cyc();
        chk("count_disabled_text_on", text_on, 0);
        cyc();

        finish_req_on = 1'b1; finish_req_bit = 3'd2; rom_data = 8'h20;
        cyc();
        finish_req_on = 1'b0;
        chk("pix_clk1_text_on", text_on, 0);
        cyc();
        chk("pix_clk2_text_on", text_on, 1);
        rom_data = 8'h10;
        #1;
        chk("pix_clk2_wrong_bit", text_on, 0);
        rom_data = 8'h20;
        cyc();
        chk("pix_clk3_text_on", text_on, 0);

        finish_req_on = 1'b1; finish_req_addr = 11'h234; rom_data = 8'hFF;
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        chk("rst_fin_state", state, 0);
        chk("rst_fin_finish_en", finish_en, 0);
        chk("rst_fin_text_on", text_on, 0);
        chk("rst_fin_rom_addr", rom_addr, 0);
        chk("rst_fin_digit", count_digit, 3);
        finish_req_on = 1'b0;

        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        m_mode = 0; m_k = 0; m_j = 0; m_addr = '0; m_on1 = 0; m_on2 = 0; m_b1 = '0; m_b2 = '0;
        model_exp();
        for (int c = 0; c < 4000; c++) begin
            reset_n = $urandom_range(0, 299) != 0;
            frame_tick = $urandom_range(0, 3) == 0;
            start = $urandom_range(0, 19) == 0;
            lap_done = $urandom_range(0, 29) == 0;
            finish_req_on = $urandom_range(0, 1) == 1;
            count_req_on = $urandom_range(0, 1) == 1;
            finish_req_addr = 11'($urandom); count_req_addr = 11'($urandom);
            finish_req_bit = 3'($urandom); count_req_bit = 3'($urandom);
            rom_data = 8'($urandom);
            @(posedge clk);
            if (!reset_n) begin
                m_mode = 0; m_k = 0; m_j = 0; m_addr = '0; m_on1 = 0; m_on2 = 0; m_b1 = '0; m_b2 = '0;
            end else begin
                m_on2 = m_on1; m_b2 = m_b1;
                m_addr = finish_req_on ? finish_req_addr : count_req_on ? count_req_addr : 11'd0;
                m_b1 = finish_req_on ? finish_req_bit : count_req_bit;
                m_on1 = finish_req_on ? e_fin : (count_req_on && e_cnt);
                case (m_mode)
                    0: if (start) begin m_mode = 1; m_k = 0; end
                    1: begin
                        if (m_k >= 3 * CF && lap_done) begin m_mode = 3; m_j = 0; end
                        else if (frame_tick && m_k < 4 * CF) m_k++;
                    end
                    default: if (frame_tick) begin
                        if (m_j == FH - 1) m_mode = 0; else m_j++;
                    end
                endcase
            end
            model_exp();
            @(negedge clk);
            chk("rnd_state", state, e_state);
            chk("rnd_digit", count_digit, e_digit);
            chk("rnd_count_en", count_en, e_cnt);
            chk("rnd_finish_en", finish_en, e_fin);
            chk("rnd_race", race_active, e_race);
            chk("rnd_rom_addr", rom_addr, m_addr);
            chk("rnd_text_on", text_on, m_on2 & rom_data[7 - m_b2]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
